// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble, one bit per clock).
// Optional build macro OVERFLOW_SAT_EN: saturate operands >= 10000 to 16'h9999.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_r;
  logic [13:0] shift_r;
  logic [19:0] work_r;
  logic [3:0]  cnt_r;
  logic [19:0] work_adj_s;
  logic        ovf_s;
  logic [15:0] result_s;

  // Per-digit +3 correction; digits never carry into each other.
  function automatic logic [19:0] add3_digits(input logic [19:0] w);
    logic [19:0] r;
    logic [3:0]  d;
    r = 20'd0;
    for (int i = 0; i < 5; i++) begin
      d = w[i*4 +: 4];
      if (d >= 4'd5) begin
        r[i*4 +: 4] = d + 4'd3;
      end else begin
        r[i*4 +: 4] = d;
      end
    end
    return r;
  endfunction

  // Digit correction and final result selection.
  always_comb begin
    work_adj_s = add3_digits(work_r);
    ovf_s      = (work_r[19:16] != 4'd0);
`ifdef OVERFLOW_SAT_EN
    if (ovf_s) begin
      result_s = 16'h9999;
    end else begin
      result_s = work_r[15:0];
    end
`else
    result_s = work_r[15:0];
`endif
  end

  // Control FSM, conversion datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      shift_r <= 14'd0;
      work_r  <= 20'd0;
      cnt_r   <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= 16'h0000;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_r <= bin_in;
            work_r  <= 20'd0;
            cnt_r   <= 4'd0;
            busy    <= 1'b1;
            state_r <= CONV;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        CONV: begin
          done               <= 1'b0;
          {work_r, shift_r}  <= {work_adj_s, shift_r} << 1;
          cnt_r              <= cnt_r + 4'd1;
          if (cnt_r == 4'd13) begin
            state_r <= DONE;
          end else begin
            state_r <= CONV;
          end
        end
        DONE: begin
          ovf     <= ovf_s;
          bcd_out <= result_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
